// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial adder sequencer: FSM state
// encodings and the width of the time-shared adder slice.
package nibble_seq_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple adder slice. Besides the carry out it exports
// the carry into bit 3, so the top level can form signed overflow on the
// most significant nibble.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       co,
  output logic       c3,
  output logic [3:0] s
);

  logic [4:0] c;

  // Bit-level ripple carry chain
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co = c[4];
  assign c3 = c[3];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder built by time-sharing one 4-bit slice, LSB nibble first, one
// nibble per clock. A carry register chains nibbles; the sum is assembled in
// an accumulator and published to s/co only at completion.
// Optional feature: define NSA_OVF_EN to add the registered signed-overflow
// output ovf.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   s,
  output logic                   co
`ifdef NSA_OVF_EN
  ,
  output logic                   ovf
`endif
);

  import nibble_seq_pkg::*;

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [W-1:0]       s_q, s_d;
  logic               co_q, co_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef NSA_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [NIB_W-1:0]   slice_a, slice_b, slice_s;
  logic               slice_co, slice_c3;

  // Select the current nibble of each captured operand for the shared slice
  always_comb begin
    slice_a = a_q[idx_q*NIB_W +: NIB_W];
    slice_b = b_q[idx_q*NIB_W +: NIB_W];
  end

  nibble_add4 u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .co  (slice_co),
    .c3  (slice_c3),
    .s   (slice_s)
  );

`ifndef NSA_OVF_EN
  // The slice always exports c3; without overflow reporting nothing needs it.
  logic unused_c3;
  assign unused_c3 = slice_c3;
`endif

  // Next-state logic: operand capture, nibble sequencing and result publish
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef NSA_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE accepts start too, giving back-to-back operation
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d[idx_q*NIB_W +: NIB_W] = slice_s;
        carry_d = slice_co;
        if (idx_q == IDX_LAST) begin
          // Publish with the final nibble already merged in
          s_d     = acc_d;
          co_d    = slice_co;
`ifdef NSA_OVF_EN
          ovf_d   = slice_c3 ^ slice_co;
`endif
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered copies of the next state decode
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef NSA_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef NSA_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
`ifdef NSA_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
